snes_multi_reader: RTL and testbench
====================================

Name: snes_multi_reader

Overview:
Parametrised SNES controller interface. It polls NUM_PADS controllers in parallel over a shared latch/clock pair and one serial data line per pad. It returns inverted (1 = pressed) button words, updated atomically once per frame. It replaces the single-pad reader inside the datapath and feeds game logic and the 7-segment display path.

Parameters:
NUM_PADS, 2, number of controllers (serial_data lines), >=1
NUM_BITS, 16, bits shifted per pad per frame (12 meaningful for standard pad)
HALF_PERIOD, 300, clk cycles per snes_clk half period (6 us at 50 MHz); must be >=4
POLL_INTERVAL, 833333, clk cycles between automatic frame starts; 0 disables auto-poll

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request one frame; honoured only in IDLE
serial_data  in  NUM_PADS  raw controller data, active-low, asynchronous
snes_clk  out  1  controller clock, idles high
data_latch  out  1  controller latch, active-high
buttons  out  NUM_PADS*NUM_BITS  pad p at [p*NUM_BITS +: NUM_BITS], bit i = button i, 1 = pressed
frame_valid  out  1  one-cycle pulse when buttons updated
busy  out  1  high while a frame is in progress

Behaviour:
- Reset (async, active-low): state IDLE, snes_clk=1, data_latch=0, buttons=0, frame_valid=0, busy=0, all counters 0, synchroniser flops 1.
- serial_data passes through a 2-flop synchroniser per pad. Sampling point is HALF_PERIOD-1 cycles after an edge, so a 2-cycle delay is safe for HALF_PERIOD>=4.
- States: IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
- IDLE: leaves on start=1 or poll timer expiry. Both in the same cycle start one frame only.
- LATCH: data_latch=1, snes_clk=1 for 2*HALF_PERIOD cycles.
- SHIFT: for bit i = 0..NUM_BITS-1:
  - High half: snes_clk=1 for HALF_PERIOD cycles. On its last cycle, each pad's synchronised bit is sampled, inverted, and stored into shift slot i.
  - Low half: snes_clk=0 for HALF_PERIOD cycles.
  - After the last low half, snes_clk returns high.
- DONE: one cycle. buttons <- shift registers (all pads together); frame_valid=1; next IDLE.
- Latency: frame_valid is high exactly 2*(NUM_BITS+1)*HALF_PERIOD+1 cycles after the edge that samples start.
- busy=1 in LATCH and SHIFT; it is 0 in DONE.
- start while busy is ignored and not queued.
- Poll timer:
  - Free-running down-counter reloaded with POLL_INTERVAL-1 at reset and on expiry.
  - An expiry while busy is dropped; the timer keeps running.
- buttons hold their previous value between frames and are never partially updated.
- Disconnected pad (line pulled high) reads as all zeros.
- Counter widths are $clog2 of the maximum value plus 1. Bit index wraps never occur: the SHIFT exit condition is index == NUM_BITS-1 at the end of the low half.

Optional Feature:
Macro SNES_EDGE_DETECT_EN.
- Defined:
  - Adds output buttons_pressed (NUM_PADS*NUM_BITS) = new buttons & ~old buttons, registered in the DONE cycle.
  - It is valid with frame_valid and cleared to 0 on the following cycle and at reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
Package snes_pkg holds:
- State enum (IDLE, LATCH, SHIFT, DONE).
- Button index constants: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
- STD_PAD_BITS=12.

One sub-module, snes_tick_gen, provides:
- The HALF_PERIOD tick counter (restart input, half_done output).
- The poll-interval timer.

Test Plan:
Use NUM_PADS=2, NUM_BITS=16, HALF_PERIOD=4, POLL_INTERVAL=0 unless stated.
1. Reset low for 3 cycles, then release -> snes_clk=1, data_latch=0, buttons=0, frame_valid=0, busy=0 throughout; no frame starts without start.
2. One-cycle start; pad0 model drives raw 16'hFEFE (B and A pressed), pad1 drives all 1 -> data_latch high 8 cycles; 16 snes_clk low pulses of 4 cycles each; frame_valid exactly 137 cycles after start; buttons = {16'h0000, 16'h0101}.
3. start re-asserted at cycles 20 and 100 of a frame -> exactly one frame_valid; no second frame until the next start in IDLE.
4. POLL_INTERVAL=200, start tied 0 -> frame_valid pulses spaced exactly 200 cycles apart. Separately, POLL_INTERVAL=100, which is shorter than a frame -> overlapping expiries are dropped and no extra frame is queued.
5. Reset pulsed low mid-SHIFT (cycle 50) after a prior frame loaded 16'h0101 -> immediately snes_clk=1, data_latch=0, buttons=0, busy=0; the next start gives a clean full frame.
6. SNES_EDGE_DETECT_EN defined, frames with pad0 = 16'h0001 then 16'h0003 -> buttons_pressed[15:0] = 16'h0001 then 16'h0002, each for one cycle with frame_valid, 0 otherwise.

Source files
------------

// File: rtl/snes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snes_pkg                                                                   |
// | Shared state encoding, button indices and width helper for the SNES reader |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package snes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } snes_state_e;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int STD_PAD_BITS = 12;

  // Counter width able to hold max_val: $clog2(max_val) + 1.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snes_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snes_tick_gen                                                              |
// | Half-period tick counter for snes_clk plus the free-running poll timer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snes_tick_gen
  import snes_pkg::*;
#(
  parameter int HALF_PERIOD   = 300,
  parameter int POLL_INTERVAL = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic half_done,
  output logic poll_expire
);

  localparam int HW = cnt_w(HALF_PERIOD - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);

  logic [HW-1:0] half_cnt_q, half_cnt_d;

  always_comb begin
    half_done  = (half_cnt_q == HALF_LAST);
    half_cnt_d = half_cnt_q + 1'b1;
    if (restart || half_done) begin
      half_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_cnt_q <= '0;
    end else begin
      half_cnt_q <= half_cnt_d;
    end
  end

  generate
    if (POLL_INTERVAL > 0) begin : g_poll
      localparam int PW = cnt_w(POLL_INTERVAL - 1);
      localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

      logic [PW-1:0] poll_cnt_q, poll_cnt_d;

      assign poll_expire = (poll_cnt_q == '0);

      always_comb begin
        poll_cnt_d = poll_cnt_q - 1'b1;
        if (poll_expire) begin
          poll_cnt_d = POLL_RELOAD;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          poll_cnt_q <= POLL_RELOAD;
        end else begin
          poll_cnt_q <= poll_cnt_d;
        end
      end
    end else begin : g_poll_off
      assign poll_expire = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/snes_multi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snes_multi_reader                                                          |
// | Polls NUM_PADS SNES pads over a shared latch/clock; optional rising-press  |
// | output when SNES_EDGE_DETECT_EN is defined.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snes_multi_reader
  import snes_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int NUM_BITS      = 16,
  parameter int HALF_PERIOD   = 300,
  parameter int POLL_INTERVAL = 833333
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_PADS-1:0]          serial_data,
  output logic                         snes_clk,
  output logic                         data_latch,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         frame_valid,
`ifdef SNES_EDGE_DETECT_EN
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_pressed,
`endif
  output logic                         busy
);

  localparam int W  = NUM_PADS * NUM_BITS;
  localparam int IW = cnt_w(NUM_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BITS - 1);

  snes_state_e   state_q, state_d;
  logic          phase_q, phase_d;  // 0 = snes_clk high half, 1 = low half
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  buttons_q, buttons_d;
  logic          fv_q, fv_d;
  logic          snes_clk_q, snes_clk_d;
  logic          latch_q, latch_d;
  logic [NUM_PADS-1:0] sync1_q, sync1_d;
  logic [NUM_PADS-1:0] sync2_q, sync2_d;

  logic half_done;
  logic poll_expire;
  logic busy_w;

  assign busy_w = (state_q == LATCH) || (state_q == SHIFT);

  snes_tick_gen #(
    .HALF_PERIOD   (HALF_PERIOD),
    .POLL_INTERVAL (POLL_INTERVAL)
  ) u_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .restart     (!busy_w),
    .half_done   (half_done),
    .poll_expire (poll_expire)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    fv_d      = 1'b0;
    sync1_d   = serial_data;
    sync2_d   = sync1_q;

    case (state_q)
      IDLE: begin
        if (start || poll_expire) begin
          state_d = LATCH;
          phase_d = 1'b0;
        end
      end
      LATCH: begin
        if (half_done) begin
          if (phase_q) begin
            state_d = SHIFT;
            phase_d = 1'b0;
            idx_d   = '0;
          end else begin
            phase_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (half_done) begin
          if (!phase_q) begin
            // Last cycle of the high half: data has been stable a full half period.
            for (int p = 0; p < NUM_PADS; p++) begin
              for (int i = 0; i < NUM_BITS; i++) begin
                if (idx_q == IW'(i)) begin
                  shift_d[p*NUM_BITS + i] = ~sync2_q[p];
                end
              end
            end
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        buttons_d = shift_q;
        fv_d      = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    snes_clk_d = !((state_d == SHIFT) && phase_d);
    latch_d    = (state_d == LATCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      idx_q      <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      fv_q       <= 1'b0;
      snes_clk_q <= 1'b1;
      latch_q    <= 1'b0;
      sync1_q    <= '1;
      sync2_q    <= '1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      fv_q       <= fv_d;
      snes_clk_q <= snes_clk_d;
      latch_q    <= latch_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

`ifdef SNES_EDGE_DETECT_EN
  logic [W-1:0] pressed_q, pressed_d;

  always_comb begin
    pressed_d = '0;
    if (state_q == DONE) begin
      pressed_d = shift_q & ~buttons_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed_q <= '0;
    end else begin
      pressed_q <= pressed_d;
    end
  end

  assign buttons_pressed = pressed_q;
`endif

  assign snes_clk    = snes_clk_q;
  assign data_latch  = latch_q;
  assign buttons     = buttons_q;
  assign frame_valid = fv_q;
  assign busy        = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_snes_multi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_snes_multi_reader                                                       |
// | Self-checking bench: pad models, vector table, scoreboard, poll timers.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_snes_multi_reader;

  localparam int NP  = 2;
  localparam int NB  = 16;
  localparam int HP  = 4;
  localparam int W   = NP * NB;
  localparam int LAT = 2 * (NB + 1) * HP + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reset2 = 1'b0;
  logic          start = 1'b0;
  logic [NP-1:0] serial_data;

  wire           snes_clk, data_latch, frame_valid, busy;
  wire [W-1:0]   buttons;
  wire           sc2, dl2, fv2, busy2, sc3, dl3, fv3, busy3;
  wire [W-1:0]   btn2, btn3;
`ifdef SNES_EDGE_DETECT_EN
  wire [W-1:0]   buttons_pressed, prs2, prs3;
`endif

  always #5 clk = ~clk;

  snes_multi_reader #(.NUM_PADS(NP), .NUM_BITS(NB), .HALF_PERIOD(HP), .POLL_INTERVAL(0)) dut (
    .clk(clk), .reset(reset), .start(start), .serial_data(serial_data),
    .snes_clk(snes_clk), .data_latch(data_latch), .buttons(buttons),
    .frame_valid(frame_valid),
`ifdef SNES_EDGE_DETECT_EN
    .buttons_pressed(buttons_pressed),
`endif
    .busy(busy));

  snes_multi_reader #(.NUM_PADS(NP), .NUM_BITS(NB), .HALF_PERIOD(HP), .POLL_INTERVAL(200)) dut_p200 (
    .clk(clk), .reset(reset2), .start(1'b0), .serial_data({NP{1'b1}}),
    .snes_clk(sc2), .data_latch(dl2), .buttons(btn2), .frame_valid(fv2),
`ifdef SNES_EDGE_DETECT_EN
    .buttons_pressed(prs2),
`endif
    .busy(busy2));

  snes_multi_reader #(.NUM_PADS(NP), .NUM_BITS(NB), .HALF_PERIOD(HP), .POLL_INTERVAL(100)) dut_p100 (
    .clk(clk), .reset(reset2), .start(1'b0), .serial_data({NP{1'b1}}),
    .snes_clk(sc3), .data_latch(dl3), .buttons(btn3), .frame_valid(fv3),
`ifdef SNES_EDGE_DETECT_EN
    .buttons_pressed(prs3),
`endif
    .busy(busy3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: latch loads bit 0, each rising snes_clk advances one bit.
  logic [NB-1:0] raw [NP];
  int pad_idx = NB;
  always @(posedge snes_clk or posedge data_latch) begin
    if (data_latch) pad_idx = 0;
    else if (pad_idx < NB) pad_idx++;
  end
  always_comb begin
    for (int p = 0; p < NP; p++) serial_data[p] = (pad_idx < NB) ? raw[p][pad_idx] : 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] btn;
    logic [W-1:0] prs;
    int           t0;
  } sb_t;
  sb_t sb[$];
  logic [W-1:0] model_prev = '0;
  logic [W-1:0] prev_exp = '0;

  int   fv_count = 0;
  logic fv_prev = 1'b0;

  always @(negedge clk) begin
    sb_t item;
    if (frame_valid) begin
      fv_count++;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 64'd1, 64'd0);
      end else begin
        item = sb.pop_front();
        chk("buttons", 64'(buttons), 64'(item.btn));
        chk("latency", 64'(cyc - item.t0), 64'(LAT));
        chk("busy_at_valid", 64'(busy), 64'd0);
`ifdef SNES_EDGE_DETECT_EN
        chk("pressed", 64'(buttons_pressed), 64'(item.prs));
`endif
      end
    end
    if (fv_prev) begin
      chk("fv_one_cycle", 64'(frame_valid), 64'd0);
`ifdef SNES_EDGE_DETECT_EN
      chk("pressed_clear", 64'(buttons_pressed), 64'd0);
`endif
    end
    fv_prev = frame_valid;
  end

  // Auto-poll monitors: every consecutive pair of frames must be 200 cycles apart.
  int n2 = 0, t2 = 0, n3 = 0, t3 = 0;
  always @(negedge clk) begin
    if (fv2) begin
      if (n2 > 0) chk("poll200_spacing", 64'(cyc - t2), 64'd200);
      chk("poll200_buttons", 64'(btn2), 64'd0);
      t2 = cyc;
      n2++;
    end
    if (fv3) begin
      if (n3 > 0) chk("poll100_spacing", 64'(cyc - t3), 64'd200);
      t3 = cyc;
      n3++;
    end
  end

  task automatic send_start(input logic [NB-1:0] r0, input logic [NB-1:0] r1, input logic [W-1:0] exp);
    sb_t item;
    raw[0] = r0;
    raw[1] = r1;
    @(negedge clk);
    start = 1'b1;
    item.btn = exp;
    item.prs = exp & ~model_prev;
    item.t0  = cyc + 1;
    model_prev = exp;
    sb.push_back(item);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input string name, output int lat, output int low, output int falls);
    int n, k;
    logic prev_sc;
    n = fv_count; k = 0; lat = 0; low = 0; falls = 0;
    prev_sc = snes_clk;
    while (fv_count == n && k < 400) begin
      if (data_latch) lat++;
      if (!snes_clk) low++;
      if (prev_sc && !snes_clk) falls++;
      prev_sc = snes_clk;
      if (k == 50) begin
        chk({name, "_busy_mid"}, 64'(busy), 64'd1);
        chk({name, "_hold_mid"}, 64'(buttons), 64'(prev_exp));
      end
      @(negedge clk);
      k++;
    end
    if (fv_count == n) chk({name, "_timeout"}, 64'd1, 64'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [NB-1:0] r0;
    logic [NB-1:0] r1;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int lat, low, falls, base;

    vecs[0] = '{16'hFEFE, 16'hFFFF, 32'h0000_0101};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'h0000_0000};
    vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000_FFFF};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 32'hA5A5_5A5A};
    vecs[4] = '{16'hF00F, 16'h7FFE, 32'h8001_0FF0};
    vecs[5] = '{16'hFFFE, 16'hFFFC, 32'h0003_0001};
    raw[0] = '1;
    raw[1] = '1;

    // Reset held for 3 cycles, then idle without start.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 64'({snes_clk, data_latch, busy, frame_valid}), 64'b1000);
      chk("reset_buttons", 64'(buttons), 64'd0);
    end
    reset = 1'b1;
    reset2 = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_outputs", 64'({snes_clk, data_latch, busy, frame_valid}), 64'b1000);
    chk("idle_no_frame", 64'(fv_count), 64'd0);

    // Vector table; waveform shape checked on every frame.
    for (int v = 0; v < 6; v++) begin
      send_start(vecs[v].r0, vecs[v].r1, vecs[v].exp);
      wait_frame("vec", lat, low, falls);
      chk("latch_cycles", 64'(lat), 64'(2 * HP));
      chk("clk_low_cycles", 64'(low), 64'(NB * HP));
      chk("clk_pulses", 64'(falls), 64'(NB));
      prev_exp = vecs[v].exp;
    end

    // start re-asserted mid-frame is ignored.
    base = fv_count;
    send_start(16'hFEFE, 16'hFFFF, 32'h0000_0101);
    repeat (18) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (79) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_frame("busy_start", lat, low, falls);
    prev_exp = 32'h0000_0101;
    repeat (60) @(negedge clk);
    chk("one_frame_only", 64'(fv_count - base), 64'd1);
    chk("idle_after_frame", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of SHIFT.
    send_start(16'hF0F0, 16'hFFFF, 32'h0000_0F0F);
    repeat (48) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 64'({snes_clk, data_latch, busy}), 64'b100);
    chk("midreset_buttons", 64'(buttons), 64'd0);
    sb.delete();
    model_prev = '0;
    prev_exp = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Clean frames after reset; press detection 0x0001 then 0x0002.
    send_start(16'hFFFE, 16'hFFFF, 32'h0000_0001);
    wait_frame("post_reset", lat, low, falls);
    chk("post_reset_pulses", 64'(falls), 64'(NB));
    prev_exp = 32'h0000_0001;
    send_start(16'hFFFC, 16'hFFFF, 32'h0000_0003);
    wait_frame("second_press", lat, low, falls);
    repeat (5) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("poll200_frames", 64'(n2 >= 3), 64'd1);
    chk("poll100_frames", 64'(n3 >= 3), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
